bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Two-master to one-slave arbiter that shares the single BRAM port between the instruction-fetch and data-memory interfaces of the core. Each request is captured and range-checked against the BRAM window, then issued to the BRAM with a registered handshake. Each granted access is bounded by a timeout counter. The block sits between the core's imem/dmem ports and the BRAM.

## Interface
Parameters:
- base_addr, 32'h80000000, inclusive lower bound of the BRAM window
- top_addr, 32'h90000000, exclusive upper bound of the BRAM window
- timeout, 1023, maximum number of BRAM wait cycles before an error response is returned

Ports:
- reset  in  1  asynchronous, active-high
- clock  in  1  single clock, rising edge
- imem_valid  in  1  fetch request, held until imem_ready
- imem_addr  in  32  fetch address
- imem_rdata  out  32  fetch data, valid when imem_ready
- imem_ready  out  1  one-cycle completion pulse
- imem_error  out  1  qualifies imem_ready: range or timeout fault
- dmem_valid  in  1  data request, held until dmem_ready
- dmem_addr  in  32  data address
- dmem_wdata  in  32  store data
- dmem_wstrb  in  4  byte enables; 0 means read
- dmem_rdata  out  32  load data, valid when dmem_ready
- dmem_ready  out  1  one-cycle completion pulse
- dmem_error  out  1  qualifies dmem_ready
- bram_valid  out  1  slave request
- bram_instr  out  1  1 when the request originates from imem
- bram_addr  out  32  slave address
- bram_wdata  out  32  slave store data
- bram_wstrb  out  4  slave byte enables
- bram_rdata  in  32  slave read data
- bram_ready  in  1  slave completion

## Operation
- FSM states:
  - IDLE
  - BUSY_I, BUSY_D: granted access in flight
  - ERR_I, ERR_D: range fault, one cycle
- IDLE:
  - Sample valids and pick a winner.
  - Capture the winner's addr, wdata and wstrb into registers. imem always uses wstrb=0 and instr=1.
  - Range check is base_addr <= addr < top_addr, unsigned 32-bit.
  - In range: go to BUSY_x and clear the counter.
  - Out of range: go to ERR_x.
- BUSY_x:
  - bram_valid=1; bram_* outputs are driven from the captured registers.
  - The master's ready and rdata pass through combinationally from bram_ready and bram_rdata.
  - On bram_ready: go to IDLE.
  - Counter increments on each cycle with bram_ready=0.
  - If counter==timeout and bram_ready=0: master ready=1, error=1, rdata=0; go to IDLE.
  - If bram_ready and the timeout coincide, bram_ready wins and a normal response is returned.
- ERR_x: master ready=1, error=1, rdata=0; go to IDLE; bram_valid stays 0.
- Non-granted master: ready, error and rdata are 0. Its valid stays asserted and is sampled again at the next IDLE.
- Master rule: valid must drop, or present a new request, in the cycle after ready. The arbiter never reissues the completed request.
- reset (asserted at any time, including mid-access):
  - State returns to IDLE, counter=0, last_grant=imem.
  - All outputs go to 0.
  - An in-flight BRAM access is abandoned; the BRAM must tolerate bram_valid dropping.

## Timing
- Request sampled in IDLE at cycle t → bram_valid=1 from cycle t+1 (registered).
- bram_ready at cycle u → master ready at u (zero added latency), IDLE at u+1.
- Minimum access: bram_ready at t+1 → master ready at t+1 → next arbitration at t+2.
- Out-of-range request at t → ready+error at t+1.
- Timeout: the error pulse occurs in the cycle where the counter equals timeout, i.e. t+1+timeout with no bram_ready. Counter width is clog2(timeout+1).
- Throughput: one access per 2 cycles maximum, since IDLE is always visited between accesses.

## Configuration
- ROUND_ROBIN_EN defined:
  - A tie (both valid in IDLE) grants the master not served last.
  - last_grant updates on every grant, including ERR grants.
  - Because reset sets last_grant=imem, the first tie goes to dmem.
- ROUND_ROBIN_EN undefined: a tie always grants dmem, and last_grant is unused.

## Test plan
- Fetch read: reset, imem_valid with addr 32'h80000010; BRAM returns 32'hDEADBEEF with bram_ready at t+1. Required: bram_valid at t+1 with bram_instr=1 and wstrb=0; imem_ready with rdata 32'hDEADBEEF at t+1; no error.
- Store: dmem addr 32'h80000020, wdata 32'h12345678, wstrb 4'b0011. Required: bram_addr, bram_wdata and bram_wstrb match and bram_instr=0; dmem_ready when bram_ready is asserted.
- Tie: both valid continuously for 4 accesses. Required with ROUND_ROBIN_EN: grants D, I, D, I. Required without it: D on every tie until dmem_valid drops.
- Range fault: dmem addr 32'h90000000 and, separately, 32'h7FFFFFFC. Required: dmem_ready=1 and dmem_error=1 at t+1 with rdata 0; bram_valid never asserted.
- Timeout: timeout=7 with bram_ready held 0. Required: imem_ready+error at t+8; bram_valid=0 at t+9. Variant: bram_ready in the same cycle gives a normal response with no error.
- Reset mid-access: assert reset during BUSY_D. Required: all outputs 0 immediately; after release, a tie grants dmem first.

Source files
------------

// File: rtl/bram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : bram_arbiter                                                  |
// | Purpose  : Shares one BRAM port between the core's instruction-fetch     |
// |            (imem) and data (dmem) interfaces. Each winning request is    |
// |            captured, range-checked against the BRAM window and issued    |
// |            with a registered bram_valid. A per-access counter returns an |
// |            error response if the BRAM does not answer in time.           |
// | Ports    : clock, reset        - rising-edge clock, async active-high    |
// |            imem_*              - fetch master (read only)                |
// |            dmem_*              - data master (wstrb == 0 means read)     |
// |            bram_*              - single slave port                       |
// | Options  : ROUND_ROBIN_EN      - defined: ties go to the master not      |
// |                                  served last; undefined: ties go to dmem |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module bram_arbiter #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] TOP_ADDR  = 32'h9000_0000,
   parameter int unsigned TIMEOUT   = 1023
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        imem_valid,
   input  logic [31:0] imem_addr,
   output logic [31:0] imem_rdata,
   output logic        imem_ready,
   output logic        imem_error,
   input  logic        dmem_valid,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_rdata,
   output logic        dmem_ready,
   output logic        dmem_error,
   output logic        bram_valid,
   output logic        bram_instr,
   output logic [31:0] bram_addr,
   output logic [31:0] bram_wdata,
   output logic [3:0]  bram_wstrb,
   input  logic [31:0] bram_rdata,
   input  logic        bram_ready
);

   // Counter must be able to hold TIMEOUT itself; keep at least one bit.
   localparam int unsigned c_cnt_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_BUSY_I = 3'd1,
      S_BUSY_D = 3'd2,
      S_ERR_I  = 3'd3,
      S_ERR_D  = 3'd4
   } state_t;

   state_t             r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [31:0]        r_addr;
   logic [31:0]        r_wdata;
   logic [3:0]         r_wstrb;

   logic        w_tie_d;
   logic        w_grant_d;
   logic        w_grant_i;
   logic [31:0] w_sel_addr;
   logic        w_in_range;
   logic        w_busy_i;
   logic        w_busy_d;
   logic        w_err_i;
   logic        w_err_d;
   logic        w_cnt_hit;

`ifdef ROUND_ROBIN_EN
   // Set when imem won the most recent grant (including range faults).
   logic r_last_imem;
   assign w_tie_d = r_last_imem;
`else
   assign w_tie_d = 1'b1;
`endif

   assign w_grant_d  = dmem_valid & (~imem_valid | w_tie_d);
   assign w_grant_i  = imem_valid & ~w_grant_d;
   assign w_sel_addr = w_grant_d ? dmem_addr : imem_addr;
   assign w_in_range = (w_sel_addr >= BASE_ADDR) && (w_sel_addr < TOP_ADDR);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
`ifdef ROUND_ROBIN_EN
         r_last_imem <= 1'b1;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               if (w_grant_d) begin
                  r_addr  <= dmem_addr;
                  r_wdata <= dmem_wdata;
                  r_wstrb <= dmem_wstrb;
                  r_state <= w_in_range ? S_BUSY_D : S_ERR_D;
`ifdef ROUND_ROBIN_EN
                  r_last_imem <= 1'b0;
`endif
               end else if (w_grant_i) begin
                  r_addr  <= imem_addr;
                  r_wdata <= '0;
                  r_wstrb <= '0;
                  r_state <= w_in_range ? S_BUSY_I : S_ERR_I;
`ifdef ROUND_ROBIN_EN
                  r_last_imem <= 1'b1;
`endif
               end
            end
            S_BUSY_I, S_BUSY_D: begin
               // A completion in the timeout cycle still counts as normal.
               if (bram_ready || (r_cnt == c_timeout)) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + c_cnt_w'(1);
               end
            end
            S_ERR_I, S_ERR_D: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_busy_i  = (r_state == S_BUSY_I);
   assign w_busy_d  = (r_state == S_BUSY_D);
   assign w_err_i   = (r_state == S_ERR_I);
   assign w_err_d   = (r_state == S_ERR_D);
   assign w_cnt_hit = (r_cnt == c_timeout) && !bram_ready;

   // Completion passes straight through from the slave; faults force rdata 0.
   assign imem_ready = (w_busy_i & (bram_ready | w_cnt_hit)) | w_err_i;
   assign imem_error = (w_busy_i & w_cnt_hit) | w_err_i;
   assign imem_rdata = (w_busy_i & bram_ready) ? bram_rdata : 32'd0;

   assign dmem_ready = (w_busy_d & (bram_ready | w_cnt_hit)) | w_err_d;
   assign dmem_error = (w_busy_d & w_cnt_hit) | w_err_d;
   assign dmem_rdata = (w_busy_d & bram_ready) ? bram_rdata : 32'd0;

   // Slave side is quiet outside of a granted access.
   assign bram_valid = w_busy_i | w_busy_d;
   assign bram_instr = w_busy_i;
   assign bram_addr  = bram_valid ? r_addr  : 32'd0;
   assign bram_wdata = bram_valid ? r_wdata : 32'd0;
   assign bram_wstrb = bram_valid ? r_wstrb : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_bram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_bram_arbiter                                               |
// | Purpose  : Directed self-checking bench for bram_arbiter (TIMEOUT = 7).  |
// |            Tie expectations follow ROUND_ROBIN_EN when it is defined.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_bram_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        imem_valid = 1'b0;
   logic [31:0] imem_addr = '0;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic        imem_error;
   logic        dmem_valid = 1'b0;
   logic [31:0] dmem_addr = '0;
   logic [31:0] dmem_wdata = '0;
   logic [3:0]  dmem_wstrb = '0;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic        dmem_error;
   logic        bram_valid;
   logic        bram_instr;
   logic [31:0] bram_addr;
   logic [31:0] bram_wdata;
   logic [3:0]  bram_wstrb;
   logic [31:0] bram_rdata = '0;
   logic        bram_ready = 1'b0;

   int checks = 0;
   int errors = 0;

   bram_arbiter #(
      .BASE_ADDR(32'h8000_0000),
      .TOP_ADDR (32'h9000_0000),
      .TIMEOUT  (7)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .imem_valid(imem_valid),
      .imem_addr (imem_addr),
      .imem_rdata(imem_rdata),
      .imem_ready(imem_ready),
      .imem_error(imem_error),
      .dmem_valid(dmem_valid),
      .dmem_addr (dmem_addr),
      .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb),
      .dmem_rdata(dmem_rdata),
      .dmem_ready(dmem_ready),
      .dmem_error(dmem_error),
      .bram_valid(bram_valid),
      .bram_instr(bram_instr),
      .bram_addr (bram_addr),
      .bram_wdata(bram_wdata),
      .bram_wstrb(bram_wstrb),
      .bram_rdata(bram_rdata),
      .bram_ready(bram_ready)
   );

   always #5 clock = ~clock;

   // Advance to just after the next rising edge; inputs are driven here.
   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      logic exp_instr;

      // ---- reset state ----
      tick();
      tick();
      #1;
      chk("rst_bram_valid", bram_valid, 0);
      chk("rst_imem_ready", imem_ready, 0);
      chk("rst_dmem_ready", dmem_ready, 0);
      reset = 1'b0;
      tick();

      // ---- fetch read, bram_ready at t+1 ----
      imem_valid = 1'b1;
      imem_addr  = 32'h8000_0010;
      tick();
      #1;
      chk("fetch_bram_valid", bram_valid, 1);
      chk("fetch_bram_instr", bram_instr, 1);
      chk("fetch_bram_wstrb", bram_wstrb, 0);
      chk("fetch_bram_addr", bram_addr, 32'h8000_0010);
      bram_ready = 1'b1;
      bram_rdata = 32'hDEAD_BEEF;
      #1;
      chk("fetch_imem_ready", imem_ready, 1);
      chk("fetch_imem_rdata", imem_rdata, 32'hDEAD_BEEF);
      chk("fetch_imem_error", imem_error, 0);
      chk("fetch_dmem_ready", dmem_ready, 0);
      tick();
      imem_valid = 1'b0;
      bram_ready = 1'b0;
      #1;
      chk("fetch_idle_valid", bram_valid, 0);

      // ---- store, one wait cycle ----
      dmem_valid = 1'b1;
      dmem_addr  = 32'h8000_0020;
      dmem_wdata = 32'h1234_5678;
      dmem_wstrb = 4'b0011;
      tick();
      #1;
      chk("store_bram_valid", bram_valid, 1);
      chk("store_bram_instr", bram_instr, 0);
      chk("store_bram_addr", bram_addr, 32'h8000_0020);
      chk("store_bram_wdata", bram_wdata, 32'h1234_5678);
      chk("store_bram_wstrb", bram_wstrb, 4'b0011);
      chk("store_wait_ready", dmem_ready, 0);
      tick();
      #1;
      chk("store_wait2_ready", dmem_ready, 0);
      bram_ready = 1'b1;
      bram_rdata = 32'h0000_0000;
      #1;
      chk("store_dmem_ready", dmem_ready, 1);
      chk("store_dmem_error", dmem_error, 0);
      tick();
      dmem_valid = 1'b0;
      dmem_wstrb = 4'b0000;
      bram_ready = 1'b0;

      // ---- range fault at top_addr ----
      dmem_valid = 1'b1;
      dmem_addr  = 32'h9000_0000;
      bram_rdata = 32'h5555_AAAA;
      tick();
      #1;
      chk("rng_hi_ready", dmem_ready, 1);
      chk("rng_hi_error", dmem_error, 1);
      chk("rng_hi_rdata", dmem_rdata, 0);
      chk("rng_hi_bvalid", bram_valid, 0);
      tick();
      dmem_valid = 1'b0;
      #1;
      chk("rng_hi_after_bvalid", bram_valid, 0);
      chk("rng_hi_after_ready", dmem_ready, 0);

      // ---- range fault below base_addr ----
      dmem_valid = 1'b1;
      dmem_addr  = 32'h7FFF_FFFC;
      tick();
      #1;
      chk("rng_lo_ready", dmem_ready, 1);
      chk("rng_lo_error", dmem_error, 1);
      chk("rng_lo_rdata", dmem_rdata, 0);
      chk("rng_lo_bvalid", bram_valid, 0);
      tick();
      dmem_valid = 1'b0;
      #1;
      chk("rng_lo_after_bvalid", bram_valid, 0);

      // ---- timeout (7): error at t+8, idle at t+9 ----
      imem_valid = 1'b1;
      imem_addr  = 32'h8000_0040;
      tick();                                   // t+1
      #1;
      chk("to_t1_bvalid", bram_valid, 1);
      chk("to_t1_ready", imem_ready, 0);
      for (int k = 2; k <= 7; k++) begin        // t+2 .. t+7
         tick();
         #1;
         chk("to_wait_ready", imem_ready, 0);
      end
      tick();                                   // t+8
      #1;
      chk("to_t8_ready", imem_ready, 1);
      chk("to_t8_error", imem_error, 1);
      chk("to_t8_rdata", imem_rdata, 0);
      imem_valid = 1'b0;
      tick();                                   // t+9
      #1;
      chk("to_t9_bvalid", bram_valid, 0);
      chk("to_t9_ready", imem_ready, 0);

      // ---- bram_ready coinciding with timeout wins ----
      imem_valid = 1'b1;
      imem_addr  = 32'h8000_0044;
      tick();                                   // t+1
      for (int k = 2; k <= 8; k++) tick();      // t+8
      bram_ready = 1'b1;
      bram_rdata = 32'hCAFE_F00D;
      #1;
      chk("to_race_ready", imem_ready, 1);
      chk("to_race_error", imem_error, 0);
      chk("to_race_rdata", imem_rdata, 32'hCAFE_F00D);
      tick();
      imem_valid = 1'b0;
      bram_ready = 1'b0;

      // ---- ties: last grant was imem, so RR starts with dmem ----
      imem_valid = 1'b1;
      imem_addr  = 32'h8000_0100;
      dmem_valid = 1'b1;
      dmem_addr  = 32'h8000_0200;
      dmem_wstrb = 4'b0000;
      for (int n = 0; n < 4; n++) begin
`ifdef ROUND_ROBIN_EN
         exp_instr = (n % 2) == 1;
`else
         exp_instr = 1'b0;
`endif
         tick();
         #1;
         chk("tie_instr", bram_instr, exp_instr);
         chk("tie_addr", bram_addr, exp_instr ? 32'h8000_0100 : 32'h8000_0200);
         bram_ready = 1'b1;
         bram_rdata = 32'h1000_0000 + n;
         #1;
         chk("tie_imem_ready", imem_ready, exp_instr);
         chk("tie_dmem_ready", dmem_ready, !exp_instr);
         tick();
         bram_ready = 1'b0;
      end
      imem_valid = 1'b0;
      dmem_valid = 1'b0;

      // ---- reset during BUSY_D ----
      dmem_valid = 1'b1;
      dmem_addr  = 32'h8000_0300;
      dmem_wdata = 32'hA5A5_5A5A;
      dmem_wstrb = 4'b1111;
      tick();
      #1;
      chk("mid_busy_bvalid", bram_valid, 1);
      reset      = 1'b1;
      bram_ready = 1'b1;
      bram_rdata = 32'h7777_7777;
      #1;
      chk("mid_rst_bvalid", bram_valid, 0);
      chk("mid_rst_baddr", bram_addr, 0);
      chk("mid_rst_bwdata", bram_wdata, 0);
      chk("mid_rst_bwstrb", bram_wstrb, 0);
      chk("mid_rst_dready", dmem_ready, 0);
      chk("mid_rst_drdata", dmem_rdata, 0);
      chk("mid_rst_derror", dmem_error, 0);
      tick();
      reset      = 1'b0;
      bram_ready = 1'b0;
      dmem_wstrb = 4'b0000;
      imem_valid = 1'b1;
      imem_addr  = 32'h8000_0400;
      tick();
      #1;
      chk("post_rst_tie_instr", bram_instr, 0);
      chk("post_rst_tie_addr", bram_addr, 32'h8000_0300);
      bram_ready = 1'b1;
      #1;
      chk("post_rst_dready", dmem_ready, 1);
      tick();
      bram_ready = 1'b0;
      imem_valid = 1'b0;
      dmem_valid = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
